// File: rtl/rs_gf_mult_arb.sv
// rs_gf_mult_arb: lets NREQ requesters share one pipelined GF(2^m) multiplier through a round-robin grant.
// Optional macro RS_GF_MULT_ARB_FIXED_PRIO_EN: fixed priority, where index 0 always wins and no rotation pointer is kept.
module rs_gf_mult_arb #(
  parameter int  m      = 8,
  parameter int  irrpol = 285,
  parameter int  NREQ   = 4,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic [NREQ-1:0]   ireq_val,
  input  logic [NREQ*m-1:0] idat_a,
  input  logic [NREQ*m-1:0] idat_b,
  output logic [NREQ-1:0]   oreq_rdy,
  output logic              oval,
  output logic [IDW-1:0]    oid,
  output logic [m-1:0]      odat
);

  localparam logic [m-1:0] POLY = irrpol[m-1:0];

  // Horner-style product: shift the partial result by x, reduce, then add a if the b bit is set.
  function automatic logic [m-1:0] gf_mult_a_by_b(input logic [m-1:0] a, input logic [m-1:0] b);
    logic [m-1:0] r;
    r = '0;
    for (int i = m - 1; i >= 0; i--) begin
      r = {r[m-2:0], 1'b0} ^ (r[m-1] ? POLY : '0);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  logic [IDW-1:0] start;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           accept;
  logic [m-1:0]   sel_a;
  logic [m-1:0]   sel_b;

  logic           s1_val_q;
  logic [m-1:0]   s1_a_q;
  logic [m-1:0]   s1_b_q;
  logic [IDW-1:0] s1_id_q;
  logic           oval_q;
  logic [IDW-1:0] oid_q;
  logic [m-1:0]   odat_q;

  always_comb begin : grant_search
    int k;
    k       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(start) + i) % NREQ;
      if (!gnt_any && ireq_val[k[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = k[IDW-1:0];
      end
    end
  end

  // A grant is only offered when this edge can actually take it.
  assign accept   = gnt_any & iclkena & ~ireset;
  assign oreq_rdy = accept ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        sel_a = idat_a[k*m +: m];
        sel_b = idat_b[k*m +: m];
      end
    end
  end

`ifdef RS_GF_MULT_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge iclk) begin
    if (ireset)       ptr_q <= '0;
    else if (iclkena) ptr_q <= ptr_d;
  end

  assign start = ptr_q;
`endif

  // Stage 1 captures the granted operands; stage 2 holds the product, tag and valid strobe.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      s1_val_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_id_q  <= '0;
      oval_q   <= 1'b0;
      oid_q    <= '0;
      odat_q   <= '0;
    end else if (iclkena) begin
      s1_val_q <= accept;
      if (accept) begin
        s1_a_q  <= sel_a;
        s1_b_q  <= sel_b;
        s1_id_q <= gnt_idx;
      end
      oval_q <= s1_val_q;
      if (s1_val_q) begin
        oid_q  <= s1_id_q;
        odat_q <= gf_mult_a_by_b(s1_a_q, s1_b_q);
      end
    end
  end

  assign oval = oval_q;
  assign oid  = oid_q;
  assign odat = odat_q;

endmodule

// File: tb/tb_rs_gf_mult_arb.sv
// tb_rs_gf_mult_arb: randomized and directed checks of rs_gf_mult_arb against a queue-based reference model.
// Honours RS_GF_MULT_ARB_FIXED_PRIO_EN when compiled with the same define as the design.
module tb_rs_gf_mult_arb;

  localparam int M    = 8;
  localparam int IRR  = 285;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [NREQ*M-1:0] da;
  logic [NREQ*M-1:0] db;
  logic [NREQ-1:0]   oreq_rdy;
  logic              oval;
  logic [IDW-1:0]    oid;
  logic [M-1:0]      odat;

  rs_gf_mult_arb #(.m(M), .irrpol(IRR), .NREQ(NREQ)) dut (
    .iclk(clk), .ireset(rst), .iclkena(ena), .ireq_val(req),
    .idat_a(da), .idat_b(db), .oreq_rdy(oreq_rdy), .oval(oval), .oid(oid), .odat(odat)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  typedef struct {int id; int a; int b; int due;} ent_t;
  ent_t           q[$];
  int             mptr;
  int             ecount;
  logic           m_val;
  logic [IDW-1:0] m_id;
  logic [M-1:0]   m_dat;

  logic [NREQ-1:0] exp_rdy, obs_rdy;
  logic            exp_val, obs_val;
  logic [IDW-1:0]  exp_id, obs_id;
  logic [M-1:0]    exp_dat, obs_dat;

  // Schoolbook carry-less product followed by polynomial long division by IRR.
  function automatic logic [M-1:0] gf_ref(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < M; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int k = 2*M - 2; k >= M; k--) if (((p >> k) & 1) != 0) p = p ^ (IRR << (k - M));
    return M'(p);
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] r, input int st);
    for (int i = 0; i < NREQ; i++) if (r[(st + i) % NREQ]) return (st + i) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    mptr = 0; ecount = 0; q.delete();
    m_val = 1'b0; m_id = '0; m_dat = '0;
  endtask

  task automatic set_op(input int k, input logic [M-1:0] a, input logic [M-1:0] b);
    da[k*M +: M] = a;
    db[k*M +: M] = b;
  endtask

  // One clock: predict, sample at negedge, then advance the model at the edge.
  task automatic tick();
    int g, st;
`ifdef RS_GF_MULT_ARB_FIXED_PRIO_EN
    st = 0;
`else
    st = mptr;
`endif
    g = model_grant(req, st);
    exp_rdy = '0;
    if (!rst && ena && g >= 0) exp_rdy[g] = 1'b1;
    exp_val = m_val; exp_id = m_id; exp_dat = m_dat;
    @(negedge clk);
    obs_rdy = oreq_rdy; obs_val = oval; obs_id = oid; obs_dat = odat;
    @(posedge clk);
    if (rst) model_reset();
    else if (ena) begin
      ecount++;
      m_val = 1'b0;
      if (q.size() > 0 && q[0].due == ecount) begin
        m_val = 1'b1; m_id = IDW'(q[0].id); m_dat = gf_ref(q[0].a, q[0].b);
        void'(q.pop_front());
      end
      if (g >= 0) begin
        q.push_back('{g, int'(da[g*M +: M]), int'(db[g*M +: M]), ecount + 1});
        mptr = (g + 1) % NREQ;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ena = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; req = '1;
    da = {$urandom, $urandom}; db = {$urandom, $urandom};
    repeat (3) begin
      tick();
      n_checks++; if (obs_rdy !== '0) begin n_fail++; $display("[TB] FAIL reset_rdy: got %b expected 0", obs_rdy); end
      n_checks++; if ({obs_val, obs_id, obs_dat} !== '0) begin n_fail++; $display("[TB] FAIL reset_out: got val %b id %0d dat %h expected all 0", obs_val, obs_id, obs_dat); end
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; set_op(2, 8'h02, 8'h80);
    tick();
    n_checks++; if (obs_rdy !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_grant: got %b expected 0100", obs_rdy); end
    req = '0;
    tick();
    n_checks++; if (obs_val !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early: got oval %b expected 0", obs_val); end
    tick();
    n_checks++; if ({obs_val, obs_id, obs_dat} !== {1'b1, 2'd2, 8'h1D}) begin n_fail++; $display("[TB] FAIL single_result: got val %b id %0d dat %h expected 1 2 1d", obs_val, obs_id, obs_dat); end
    n_checks++; if (obs_dat !== exp_dat) begin n_fail++; $display("[TB] FAIL single_model: got %h expected %h", obs_dat, exp_dat); end
  endtask

  task automatic test_two_req();
    int gq[$], gc[$], oq[$], oc[$];
    logic [M-1:0] dq[$];
    rst = 1'b1; ena = 1'b1; req = 4'b0011;
    set_op(0, 8'h02, 8'h8E); set_op(1, 8'h03, 8'h03);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL two_grant: got %b expected %b", obs_rdy, exp_rdy); end
      for (int k = 0; k < NREQ; k++) if (obs_rdy[k]) begin gq.push_back(k); gc.push_back(c); req[k] = 1'b0; end
      if (obs_val) begin oq.push_back(int'(obs_id)); oc.push_back(c); dq.push_back(obs_dat); end
    end
    n_checks++;
    if (gq.size() != 2 || oq.size() != 2) begin
      n_fail++; $display("[TB] FAIL two_counts: got %0d grants %0d results expected 2 2", gq.size(), oq.size());
    end else begin
      if (gq[0] != 0 || gq[1] != 1 || gc[1] != gc[0] + 1) begin n_fail++; $display("[TB] FAIL two_order: got %0d@%0d %0d@%0d expected 0 then 1 back to back", gq[0], gc[0], gq[1], gc[1]); end
      n_checks++;
      if (oq[0] != 0 || dq[0] !== 8'h01 || oq[1] != 1 || dq[1] !== 8'h05 || oc[1] != oc[0] + 1)
        begin n_fail++; $display("[TB] FAIL two_results: got %0d/%h %0d/%h expected 0/01 1/05 consecutive", oq[0], dq[0], oq[1], dq[1]); end
    end
  endtask

  task automatic test_rotation();
    int seq[$];
    int cnt[NREQ];
    int pulses;
    do_reset();
    for (int k = 0; k < NREQ; k++) begin cnt[k] = 0; set_op(k, M'($urandom), M'($urandom)); end
    pulses = 0; req = '1;
    for (int c = 0; c < 15; c++) begin
      if (c == 12) req = '0;
      tick();
      n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL rot_grant: got %b expected %b", obs_rdy, exp_rdy); end
      n_checks++; if (obs_val !== exp_val) begin n_fail++; $display("[TB] FAIL rot_oval: got %b expected %b", obs_val, exp_val); end
      if (exp_val) begin n_checks++; if (obs_id !== exp_id || obs_dat !== exp_dat) begin n_fail++; $display("[TB] FAIL rot_result: got %0d/%h expected %0d/%h", obs_id, obs_dat, exp_id, exp_dat); end end
      if (obs_val) pulses++;
      for (int k = 0; k < NREQ; k++) if (obs_rdy[k]) begin cnt[k]++; seq.push_back(k); set_op(k, M'($urandom), M'($urandom)); end
    end
    n_checks++; if (pulses != 12) begin n_fail++; $display("[TB] FAIL rot_pulses: got %0d expected 12", pulses); end
    n_checks++; if (seq.size() != 12) begin n_fail++; $display("[TB] FAIL rot_len: got %0d expected 12", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
`ifdef RS_GF_MULT_ARB_FIXED_PRIO_EN
      n_checks++; if (seq[i] != 0) begin n_fail++; $display("[TB] FAIL rot_seq: got %0d at %0d expected 0", seq[i], i); end
`else
      n_checks++; if (seq[i] != i % NREQ) begin n_fail++; $display("[TB] FAIL rot_seq: got %0d at %0d expected %0d", seq[i], i, i % NREQ); end
`endif
    end
`ifndef RS_GF_MULT_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      n_checks++; if (cnt[k] != 3) begin n_fail++; $display("[TB] FAIL rot_count: req %0d got %0d expected 3", k, cnt[k]); end
    end
`endif
  endtask

  task automatic test_zero_one();
    logic [M-1:0] dq[$];
    do_reset();
    req = 4'b1000; set_op(3, 8'h00, 8'hAB);
    tick();
    n_checks++; if (obs_rdy !== 4'b1000) begin n_fail++; $display("[TB] FAIL zo_grant1: got %b expected 1000", obs_rdy); end
    set_op(3, 8'h01, 8'hAB);
    tick();
    n_checks++; if (obs_rdy !== 4'b1000) begin n_fail++; $display("[TB] FAIL zo_grant2: got %b expected 1000", obs_rdy); end
    req = 4'b1001; set_op(0, 8'h02, 8'h80);
    tick();
    n_checks++; if (obs_rdy !== 4'b0001) begin n_fail++; $display("[TB] FAIL zo_wrap: got %b expected 0001", obs_rdy); end
    if (obs_val) dq.push_back(obs_dat);
    req = '0;
    repeat (3) begin tick(); if (obs_val) dq.push_back(obs_dat); end
    n_checks++;
    if (dq.size() != 3) begin n_fail++; $display("[TB] FAIL zo_count: got %0d results expected 3", dq.size()); end
    else if (dq[0] !== 8'h00 || dq[1] !== 8'hAB || dq[2] !== 8'h1D) begin n_fail++; $display("[TB] FAIL zo_values: got %h %h %h expected 00 ab 1d", dq[0], dq[1], dq[2]); end
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b0001; set_op(0, 8'h02, 8'h8E);
    tick();
    req = 4'b0010; set_op(1, 8'h03, 8'h03); ena = 1'b0;
    repeat (5) begin
      tick();
      n_checks++; if (obs_rdy !== '0 || obs_val !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_frozen: got rdy %b val %b expected 0 0", obs_rdy, obs_val); end
    end
    ena = 1'b1; req = '0;
    tick();
    n_checks++; if (obs_val !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_early: got oval %b expected 0", obs_val); end
    tick();
    n_checks++; if ({obs_val, obs_id, obs_dat} !== {1'b1, 2'd0, 8'h01}) begin n_fail++; $display("[TB] FAIL stall_result: got %b/%0d/%h expected 1/0/01", obs_val, obs_id, obs_dat); end
    tick();
    n_checks++; if (obs_val !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_strobe: got oval %b expected 0", obs_val); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0011; set_op(0, 8'h11, 8'h22); set_op(1, 8'h33, 8'h44);
    tick();
    req = 4'b0010;
    tick();
    req = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      n_checks++; if (obs_val !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_discard: got oval %b expected 0", obs_val); end
    end
    req = 4'b1010;
    tick();
    n_checks++; if (obs_rdy !== 4'b0010) begin n_fail++; $display("[TB] FAIL rmid_ptr: got %b expected 0010", obs_rdy); end
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req[k] && $urandom_range(3) == 0) begin req[k] = 1'b1; set_op(k, M'($urandom), M'($urandom)); end
        else if (req[k] && $urandom_range(15) == 0) req[k] = 1'b0;
      end
      ena = ($urandom_range(7) != 0);
      rst = ($urandom_range(63) == 0);
      tick();
      n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL rnd_grant: cyc %0d got %b expected %b", c, obs_rdy, exp_rdy); end
      n_checks++; if (obs_val !== exp_val) begin n_fail++; $display("[TB] FAIL rnd_oval: cyc %0d got %b expected %b", c, obs_val, exp_val); end
      if (exp_val) begin n_checks++; if (obs_id !== exp_id || obs_dat !== exp_dat) begin n_fail++; $display("[TB] FAIL rnd_result: cyc %0d got %0d/%h expected %0d/%h", c, obs_id, obs_dat, exp_id, exp_dat); end end
      for (int k = 0; k < NREQ; k++) if (obs_rdy[k]) begin
        if ($urandom_range(1) == 0) req[k] = 1'b0;
        else set_op(k, M'($urandom), M'($urandom));
      end
    end
    rst = 1'b0; ena = 1'b1; req = '0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; ena = 1'b1; req = '0; da = '0; db = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    test_reset();
    test_single();
    test_two_req();
    test_rotation();
    test_zero_one();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
